// File: rtl/bram_pkg.sv
// bram_pkg: shared state encodings, read-during-write modes and byte-merge helper.
// Rev 1.0
`default_nettype none

package bram_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_CLEAR = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OUT_ZERO   = 2'd0,
      OUT_RAW    = 2'd1,
      OUT_MERGED = 2'd2
   } out_sel_t;

   localparam int RDW_READ_FIRST  = 0;
   localparam int RDW_WRITE_FIRST = 1;
   localparam int RDW_NO_CHANGE   = 2;

   // Widest word the merge helper handles; callers zero-extend and truncate.
   localparam int MERGE_MAX_W = 256;

   function automatic logic [MERGE_MAX_W-1:0] byte_merge(
      input logic [MERGE_MAX_W-1:0]   old_word,
      input logic [MERGE_MAX_W-1:0]   new_word,
      input logic [MERGE_MAX_W/8-1:0] be
   );
      logic [MERGE_MAX_W-1:0] merged;
      merged = old_word;
      for (int i = 0; i < MERGE_MAX_W/8; i++) begin
         if (be[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sp_bram_array.sv
// sp_bram_array: byte-enable write / registered read storage, no reset (BRAM inferable).
// Rev 1.0
`default_nettype none

module sp_bram_array #(
   parameter int DATA_WIDTH    = 32,
   parameter int DEPTH         = 64,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      we,
   input  logic                      re,
   input  logic [DATA_WIDTH/8-1:0]   be,
   input  logic [ADDRESS_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0]     wdata,
   output logic [DATA_WIDTH-1:0]     rdata
);

   localparam int BYTES = DATA_WIDTH/8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Read sees the pre-write word on a same-address access (read-first port).
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BYTES; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      if (re) rdata <= mem[addr];
   end

endmodule

`default_nettype wire

// File: rtl/sp_bram_ctrl.sv
// sp_bram_ctrl: single-port BRAM controller with clear sequencer, range check and RDW muxing.
// Rev 1.0
`default_nettype none

module sp_bram_ctrl
   import bram_pkg::*;
#(
   parameter int                     DATA_WIDTH    = 32,
   parameter int                     DEPTH         = 64,
   parameter int                     ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int                     RDW_MODE      = 0,
   parameter logic [DATA_WIDTH-1:0]  CLR_VALUE     = '0
) (
   input  logic                      clk,
   input  logic                      n_clr,
   input  logic                      clr_req,
   input  logic                      req,
   input  logic                      write_en,
   input  logic [DATA_WIDTH/8-1:0]   byte_en,
   input  logic [ADDRESS_WIDTH-1:0]  addr,
   input  logic [DATA_WIDTH-1:0]     data_in,
   output logic                      ready,
   output logic                      clr_busy,
   output logic [DATA_WIDTH-1:0]     data_out,
   output logic                      data_valid,
   output logic                      addr_err
);

   localparam logic [ADDRESS_WIDTH:0]   DEPTH_EXT = (ADDRESS_WIDTH+1)'(DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH-1);
   localparam bit                       NO_CHANGE = (RDW_MODE == RDW_NO_CHANGE);
   localparam bit                       WR_FIRST  = (RDW_MODE == RDW_WRITE_FIRST);

   state_t                    r_state, w_state_nxt;
   logic [ADDRESS_WIDTH-1:0]  r_sweep, w_sweep_nxt;
   logic                      r_valid, r_err;
   out_sel_t                  r_sel;
   logic [DATA_WIDTH-1:0]     r_wdata, r_hold;
   logic [DATA_WIDTH/8-1:0]   r_be;

   logic                      w_accept, w_in_range;
   logic                      w_mem_we, w_mem_re;
   logic [DATA_WIDTH/8-1:0]   w_mem_be;
   logic [ADDRESS_WIDTH-1:0]  w_mem_addr;
   logic [DATA_WIDTH-1:0]     w_mem_wdata, w_mem_rdata, w_resp;

   assign w_in_range = ({1'b0, addr} < DEPTH_EXT);
   assign w_accept   = ready && req;

   always_comb begin
      w_state_nxt = r_state;
      w_sweep_nxt = r_sweep;
      ready       = 1'b0;
      clr_busy    = 1'b1;
      w_mem_we    = 1'b0;
      w_mem_re    = 1'b0;
      w_mem_be    = '0;
      w_mem_addr  = addr;
      w_mem_wdata = data_in;
      case (r_state)
         ST_INIT, ST_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_be    = '1;
            w_mem_addr  = r_sweep;
            w_mem_wdata = CLR_VALUE;
            if (r_sweep == LAST_ADDR) begin
               w_sweep_nxt = '0;
               w_state_nxt = ST_IDLE;
            end else begin
               w_sweep_nxt = r_sweep + 1'b1;
            end
         end
         ST_IDLE: begin
            ready    = 1'b1;
            clr_busy = 1'b0;
            // Out-of-range accesses never touch the array.
            if (req && w_in_range) begin
               w_mem_we = write_en;
               w_mem_be = byte_en;
               w_mem_re = !(write_en && NO_CHANGE);
            end
            if (clr_req) begin
               w_state_nxt = ST_CLEAR;
               w_sweep_nxt = '0;
            end
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge n_clr) begin
      if (!n_clr) begin
         r_state <= ST_INIT;
         r_sweep <= '0;
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         r_sel   <= OUT_ZERO;
         r_wdata <= '0;
         r_be    <= '0;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sweep <= w_sweep_nxt;
         r_hold  <= data_out;
         r_err   <= w_accept && !w_in_range;
         r_valid <= w_accept && !(write_en && NO_CHANGE);
         if (!w_in_range)              r_sel <= OUT_ZERO;
         else if (write_en && WR_FIRST) r_sel <= OUT_MERGED;
         else                          r_sel <= OUT_RAW;
         if (w_accept && write_en) begin
            r_wdata <= data_in;
            r_be    <= byte_en;
         end
      end
   end

   sp_bram_array #(
      .DATA_WIDTH    (DATA_WIDTH),
      .DEPTH         (DEPTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
   ) u_array (
      .clk   (clk),
      .we    (w_mem_we),
      .re    (w_mem_re),
      .be    (w_mem_be),
      .addr  (w_mem_addr),
      .wdata (w_mem_wdata),
      .rdata (w_mem_rdata)
   );

   // Write-first merges the registered write data over the old word read alongside it.
   always_comb begin
      w_resp = '0;
      case (r_sel)
         OUT_RAW:    w_resp = w_mem_rdata;
         OUT_MERGED: w_resp = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(w_mem_rdata),
                                                     MERGE_MAX_W'(r_wdata),
                                                     (MERGE_MAX_W/8)'(r_be)));
         default:    w_resp = '0;
      endcase
   end

   assign data_out   = r_valid ? w_resp : r_hold;
   assign data_valid = r_valid;
   assign addr_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sp_bram_ctrl.sv
// tb_sp_bram_ctrl: directed checks of sp_bram_ctrl in all RDW modes and with a 48-word array.
// Rev 1.0
`default_nettype none

module tb_sp_bram_ctrl;

   logic        clk = 1'b0;
   logic        n_clr = 1'b0;
   logic        clr_req = 1'b0;
   logic        req = 1'b0;
   logic        write_en = 1'b0;
   logic [3:0]  byte_en = 4'h0;
   logic [5:0]  addr = 6'd0;
   logic [31:0] data_in = 32'h0;

   // Index 0: read-first, 1: write-first, 2: no-change (all 64 deep); 3: 48 deep read-first.
   logic        rdy [4];
   logic        bsy [4];
   logic        vld [4];
   logic        err [4];
   logic [31:0] dout [4];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   sp_bram_ctrl #(.DEPTH(64), .RDW_MODE(0)) u_rf (
      .clk(clk), .n_clr(n_clr), .clr_req(clr_req), .req(req), .write_en(write_en),
      .byte_en(byte_en), .addr(addr), .data_in(data_in), .ready(rdy[0]), .clr_busy(bsy[0]),
      .data_out(dout[0]), .data_valid(vld[0]), .addr_err(err[0]));

   sp_bram_ctrl #(.DEPTH(64), .RDW_MODE(1)) u_wf (
      .clk(clk), .n_clr(n_clr), .clr_req(clr_req), .req(req), .write_en(write_en),
      .byte_en(byte_en), .addr(addr), .data_in(data_in), .ready(rdy[1]), .clr_busy(bsy[1]),
      .data_out(dout[1]), .data_valid(vld[1]), .addr_err(err[1]));

   sp_bram_ctrl #(.DEPTH(64), .RDW_MODE(2)) u_nc (
      .clk(clk), .n_clr(n_clr), .clr_req(clr_req), .req(req), .write_en(write_en),
      .byte_en(byte_en), .addr(addr), .data_in(data_in), .ready(rdy[2]), .clr_busy(bsy[2]),
      .data_out(dout[2]), .data_valid(vld[2]), .addr_err(err[2]));

   sp_bram_ctrl #(.DEPTH(48), .RDW_MODE(0), .CLR_VALUE(32'hC1C1C1C1)) u_d48 (
      .clk(clk), .n_clr(n_clr), .clr_req(clr_req), .req(req), .write_en(write_en),
      .byte_en(byte_en), .addr(addr), .data_in(data_in), .ready(rdy[3]), .clr_busy(bsy[3]),
      .data_out(dout[3]), .data_valid(vld[3]), .addr_err(err[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic access(input logic we, input logic [3:0] be, input logic [5:0] a,
                         input logic [31:0] d);
      req      = 1'b1;
      write_en = we;
      byte_en  = be;
      addr     = a;
      data_in  = d;
      tick();
      req      = 1'b0;
      write_en = 1'b0;
   endtask

   // Cycles until each instance reports ready; -1 if the budget runs out.
   task automatic wait_ready(output int n64, output int n48);
      n64 = -1;
      n48 = -1;
      for (int c = 1; c <= 200; c++) begin
         tick();
         if (n48 < 0 && rdy[3]) n48 = c;
         if (n64 < 0 && rdy[0]) n64 = c;
         if (n64 >= 0 && n48 >= 0) break;
      end
   endtask

   initial begin
      int n64, n48, n, vcount;

      // Reset state
      tick();
      tick();
      chk1("rst_ready",    rdy[0], 1'b0);
      chk1("rst_clr_busy", bsy[0], 1'b1);
      chk ("rst_data_out", dout[0], 32'h0);
      chk1("rst_valid",    vld[0], 1'b0);
      chk1("rst_addr_err", err[0], 1'b0);

      // Init sweep length
      n_clr = 1'b1;
      wait_ready(n64, n48);
      chk("init_len_64", 32'(n64), 32'd64);
      chk("init_len_48", 32'(n48), 32'd48);

      // Freshly initialised reads
      access(1'b0, 4'h0, 6'd0, 32'h0);
      chk ("init_rd0",       dout[0], 32'h0);
      chk1("init_rd0_valid", vld[0], 1'b1);
      chk ("init_rd0_d48",   dout[3], 32'hC1C1C1C1);
      access(1'b0, 4'h0, 6'd17, 32'h0);
      chk ("init_rd17",      dout[0], 32'h0);
      chk ("init_rd17_d48",  dout[3], 32'hC1C1C1C1);
      access(1'b0, 4'h0, 6'd63, 32'h0);
      chk ("init_rd63",      dout[0], 32'h0);
      chk1("init_rd63_valid", vld[0], 1'b1);

      // Full and partial writes with read-back
      access(1'b1, 4'hF, 6'd5, 32'hDEADBEEF);
      chk ("wr5_rf_old",   dout[0], 32'h0);
      chk1("wr5_rf_valid", vld[0], 1'b1);
      chk ("wr5_wf_new",   dout[1], 32'hDEADBEEF);
      chk1("wr5_nc_valid", vld[2], 1'b0);
      access(1'b0, 4'h0, 6'd5, 32'h0);
      chk ("rd5_rf",       dout[0], 32'hDEADBEEF);
      chk1("rd5_rf_valid", vld[0], 1'b1);
      chk ("rd5_nc",       dout[2], 32'hDEADBEEF);
      access(1'b1, 4'b0101, 6'd5, 32'h11223344);
      chk ("bwr5_rf_old",  dout[0], 32'hDEADBEEF);
      chk ("bwr5_wf_merge", dout[1], 32'hDE22BE44);
      chk1("bwr5_nc_valid", vld[2], 1'b0);
      chk ("bwr5_nc_hold", dout[2], 32'hDEADBEEF);
      access(1'b0, 4'h0, 6'd5, 32'h0);
      chk ("rd5b_rf",      dout[0], 32'hDE22BE44);
      chk ("rd5b_nc",      dout[2], 32'hDE22BE44);

      // Read-during-write modes at addr 9
      access(1'b1, 4'hF, 6'd9, 32'h12345678);
      access(1'b1, 4'hF, 6'd9, 32'hAAAA5555);
      chk ("rdw_rf",       dout[0], 32'h12345678);
      chk ("rdw_wf",       dout[1], 32'hAAAA5555);
      chk1("rdw_wf_valid", vld[1], 1'b1);
      chk1("rdw_nc_valid", vld[2], 1'b0);
      chk ("rdw_nc_hold",  dout[2], 32'hDE22BE44);
      access(1'b1, 4'h0, 6'd9, 32'hFFFFFFFF);
      chk ("be0_rf",       dout[0], 32'hAAAA5555);
      chk ("be0_wf",       dout[1], 32'hAAAA5555);
      access(1'b0, 4'h0, 6'd9, 32'h0);
      chk ("be0_rd9",      dout[0], 32'hAAAA5555);

      // Out-of-range accesses on the 48-word instance
      access(1'b1, 4'hF, 6'd47, 32'hCAFEF00D);
      access(1'b0, 4'h0, 6'd50, 32'h0);
      chk ("oor_rd_data",  dout[3], 32'h0);
      chk1("oor_rd_valid", vld[3], 1'b1);
      chk1("oor_rd_err",   err[3], 1'b1);
      chk1("inr_rd_err64", err[0], 1'b0);
      tick();
      chk1("oor_err_pulse", err[3], 1'b0);
      access(1'b1, 4'hF, 6'd50, 32'h55555555);
      chk1("oor_wr_err",   err[3], 1'b1);
      access(1'b0, 4'h0, 6'd47, 32'h0);
      chk ("oor_rd47",     dout[3], 32'hCAFEF00D);
      chk1("oor_rd47_err", err[3], 1'b0);
      access(1'b0, 4'h0, 6'd5, 32'h0);
      chk ("oor_rd5",      dout[3], 32'hDE22BE44);
      access(1'b0, 4'h0, 6'd50, 32'h0);
      chk ("rd50_d64",     dout[0], 32'h55555555);

      // clr_req alongside a write
      clr_req = 1'b1;
      access(1'b1, 4'hF, 6'd3, 32'h33333333);
      clr_req = 1'b0;
      chk1("clr_wr_valid", vld[0], 1'b1);
      chk ("clr_wr_wf",    dout[1], 32'h33333333);
      chk1("clr_ready",    rdy[0], 1'b0);
      chk1("clr_busy",     bsy[0], 1'b1);
      req    = 1'b1;
      addr   = 6'd3;
      n      = 0;
      vcount = 0;
      while (!rdy[0] && n < 200) begin
         tick();
         n++;
         if (vld[0]) vcount++;
      end
      req = 1'b0;
      chk("clr_len",        32'(n), 32'd64);
      chk("clr_req_ignored", 32'(vcount), 32'd0);
      access(1'b0, 4'h0, 6'd3, 32'h0);
      chk ("clr_rd3_rf",   dout[0], 32'h0);
      chk ("clr_rd3_wf",   dout[1], 32'h0);
      chk ("clr_rd3_d48",  dout[3], 32'hC1C1C1C1);

      // Reset drops a pending response
      access(1'b0, 4'h0, 6'd9, 32'h0);
      chk1("pre_rst_valid", vld[0], 1'b1);
      n_clr = 1'b0;
      #1;
      chk1("rst_drop_valid", vld[0], 1'b0);
      chk ("rst_drop_data",  dout[0], 32'h0);
      chk1("rst_drop_ready", rdy[0], 1'b0);
      tick();
      n_clr = 1'b1;

      // Reset at sweep index 20 restarts the sweep
      repeat (20) tick();
      chk1("mid_sweep_busy", bsy[0], 1'b1);
      n_clr = 1'b0;
      tick();
      n_clr = 1'b1;
      wait_ready(n64, n48);
      chk("restart_len_64", 32'(n64), 32'd64);
      chk("restart_len_48", 32'(n48), 32'd48);
      access(1'b0, 4'h0, 6'd47, 32'h0);
      chk ("restart_rd47_d48", dout[3], 32'hC1C1C1C1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
